// File: rtl/bit_dup_fill_if.sv
// Command and output-word handshake bundle for the bit duplication fill stage.
// The slave modport is the fill stage's view; master is the command source / word sink.
interface bit_dup_fill_if #(
  parameter int OUT_WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [7:0]           in_pattern;
  logic [2:0]           in_width;
  logic [7:0]           in_count;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_last;

  modport slave (
    input  in_valid, in_pattern, in_width, in_count, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_pattern, in_width, in_count, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/bit_dup_fill.sv
// Pattern-fill stage: one command (pattern, width, count) becomes count replicated words.
// First word one cycle after accept, one word per cycle; words and state hold while out_ready is low.
module bit_dup_fill #(
  parameter int OUT_WIDTH = 32
) (
  input  logic             clock,
  input  logic             rst_n,
  bit_dup_fill_if.slave    bus,
  output logic             busy
);

  localparam int EXT_W  = OUT_WIDTH + 8;
  localparam int EXT_IW = $clog2(EXT_W);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           pat_q, pat_d;
  logic [3:0]           w_q, w_d;
  logic [2:0]           phase_q, phase_d;
  logic [7:0]           remaining_q, remaining_d;
  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic                 last_q, last_d;

  logic [7:0]           pat_masked;
  logic [3:0]           w_cmd;
  logic [2:0]           phase_next;

  // The pattern repeated with period w over OUT_WIDTH+8 bits; shifting by the
  // phase (< 8) then yields the word starting at that point of the pattern.
  function automatic logic [OUT_WIDTH-1:0] make_word(input logic [7:0] pat,
                                                     input logic [3:0] w,
                                                     input logic [2:0] ph);
    logic [EXT_W-1:0] ext;
    logic [EXT_W-1:0] shifted;
    ext = '0;
    for (int k = 1; k <= 8; k++) begin
      if (w == 4'(k)) begin
        for (int i = 0; i < EXT_W; i++) begin
          ext[EXT_IW'(i)] = pat[3'(i % k)];
        end
      end
    end
    shifted = ext >> ph;
    return shifted[OUT_WIDTH-1:0];
  endfunction

  // OUT_WIDTH mod w per width; widths 1, 2, 4 and 8 divide OUT_WIDTH so the phase never moves.
  function automatic logic [2:0] phase_adv(input logic [2:0] ph, input logic [3:0] w);
    logic [3:0] step;
    logic [3:0] sum;
    case (w)
      4'd3:    step = 4'(OUT_WIDTH % 3);
      4'd5:    step = 4'(OUT_WIDTH % 5);
      4'd6:    step = 4'(OUT_WIDTH % 6);
      4'd7:    step = 4'(OUT_WIDTH % 7);
      default: step = 4'd0;
    endcase
    sum = {1'b0, ph} + step;
    if (sum >= w) begin
      sum = sum - w;
    end
    return sum[2:0];
  endfunction

  always_comb begin
    pat_masked = '0;
    for (int i = 0; i < 8; i++) begin
      pat_masked[i] = bus.in_pattern[i] & (3'(i) <= bus.in_width);
    end
  end

  assign w_cmd      = {1'b0, bus.in_width} + 4'd1;
  assign phase_next = phase_adv(phase_q, w_q);

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    w_d         = w_q;
    phase_d     = phase_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    last_d      = last_q;
    case (state_q)
      IDLE: begin
        // A zero-count command is still accepted, it just produces nothing.
        if (bus.in_valid && (bus.in_count != 8'd0)) begin
          state_d     = EMIT;
          pat_d       = pat_masked;
          w_d         = w_cmd;
          phase_d     = 3'd0;
          remaining_d = bus.in_count;
          data_d      = make_word(pat_masked, w_cmd, 3'd0);
          last_d      = (bus.in_count == 8'd1);
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (remaining_q > 8'd1) begin
            phase_d     = phase_next;
            remaining_d = remaining_q - 8'd1;
            data_d      = make_word(pat_q, w_q, phase_next);
            last_d      = (remaining_q == 8'd2);
          end else begin
            state_d     = IDLE;
            remaining_d = 8'd0;
            last_d      = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pat_q       <= '0;
      w_q         <= 4'd1;
      phase_q     <= 3'd0;
      remaining_q <= 8'd0;
      data_q      <= '0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      w_q         <= w_d;
      phase_q     <= phase_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      last_q      <= last_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_data  = data_q;
  assign bus.out_last  = last_q;
  assign busy          = (state_q == EMIT);

endmodule
